// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: Y86-64 stage sequencer, 6 cycles/instr plus one per data-memory wait; stalls in MEMORY until mem_ack or timeout.
// Optional macro SEQ_CTRL_PERF_EN builds the retired/stall_cycles counters; without it those ports read 0.
module seq_stage_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    input  logic        alu_zf,
    input  logic        alu_sf,
    input  logic        alu_of,
    input  logic        mem_ack,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        m_en,
    output logic        w_en,
    output logic        pc_en,
    output logic        mem_req,
    output logic [2:0]  cc,
    output logic        cnd,
    output logic [1:0]  stat,
    output logic        busy,
    output logic [31:0] retired,
    output logic [31:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic        f_en_q, f_en_d, d_en_q, d_en_d, e_en_q, e_en_d;
    logic        w_en_q, w_en_d, pc_en_q, pc_en_d;
    logic        mem_req_q, mem_req_d, busy_q, busy_d;
    logic [2:0]  cc_q, cc_d;
    logic        cnd_q, cnd_d;
    logic [1:0]  stat_q, stat_d;
    logic [7:0]  wait_q, wait_d;
    logic        need_mem, cond_hit, zf, sf, of;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        need_mem = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                   (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);
        case (ifun)
            4'h0:    cond_hit = 1'b1;
            4'h1:    cond_hit = (sf ^ of) | zf;
            4'h2:    cond_hit = sf ^ of;
            4'h3:    cond_hit = zf;
            4'h4:    cond_hit = ~zf;
            4'h5:    cond_hit = ~(sf ^ of);
            4'h6:    cond_hit = ~(sf ^ of) & ~zf;
            default: cond_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        armed_d = 1'b1;
        cc_d    = cc_q;
        cnd_d   = cnd_q;
        stat_d  = stat_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                // The first edge after reset release only arms the sequencer.
                if (start && armed_q) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    stat_d  = 2'd2;
                    state_d = S_HALTED;
                end else if (!instr_valid) begin
                    stat_d  = 2'd3;
                    state_d = S_HALTED;
                end else if (icode == 4'h0) begin
                    stat_d  = 2'd1;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (icode == 4'h6) cc_d = {alu_zf, alu_sf, alu_of};
                cnd_d   = ((icode == 4'h2) || (icode == 4'h7)) ? cond_hit : 1'b0;
                wait_d  = 8'd0;
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (!mem_req_q) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ack) begin
                    if (dmem_error) begin
                        stat_d  = 2'd2;
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d == TIMEOUT) begin
                        stat_d  = 2'd2;
                        state_d = S_HALTED;
                    end
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD:     state_d = S_FETCH;
            S_HALTED:    state_d = S_HALTED;
            default:     state_d = S_IDLE;
        endcase

        f_en_d    = (state_d == S_FETCH);
        d_en_d    = (state_d == S_DECODE);
        e_en_d    = (state_d == S_EXECUTE);
        w_en_d    = (state_d == S_WRITEBACK);
        pc_en_d   = (state_d == S_PCUPD);
        mem_req_d = (state_d == S_MEMORY) && need_mem;
        busy_d    = (state_d != S_IDLE) && (state_d != S_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            f_en_q    <= 1'b0;
            d_en_q    <= 1'b0;
            e_en_q    <= 1'b0;
            w_en_q    <= 1'b0;
            pc_en_q   <= 1'b0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            cc_q      <= 3'b100;
            cnd_q     <= 1'b0;
            stat_q    <= 2'd0;
            wait_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            f_en_q    <= f_en_d;
            d_en_q    <= d_en_d;
            e_en_q    <= e_en_d;
            w_en_q    <= w_en_d;
            pc_en_q   <= pc_en_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            cc_q      <= cc_d;
            cnd_q     <= cnd_d;
            stat_q    <= stat_d;
            wait_q    <= wait_d;
        end
    end

    // Completion of a memory access is only known in the cycle mem_ack arrives.
    assign m_en    = (state_q == S_MEMORY) && (!mem_req_q || (mem_ack && !dmem_error));
    assign f_en    = f_en_q;
    assign d_en    = d_en_q;
    assign e_en    = e_en_q;
    assign w_en    = w_en_q;
    assign pc_en   = pc_en_q;
    assign mem_req = mem_req_q;
    assign busy    = busy_q;
    assign cc      = cc_q;
    assign cnd     = cnd_q;
    assign stat    = stat_q;

`ifdef SEQ_CTRL_PERF_EN
    logic [31:0] retired_q, retired_d, stall_q, stall_d;

    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (state_q == S_PCUPD) retired_d = retired_q + 32'd1;
        if ((state_q == S_MEMORY) && mem_req_q && !mem_ack) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired      = retired_q;
    assign stall_cycles = stall_q;
`else
    assign retired      = 32'd0;
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: per-cycle strobe expectations queued as stimulus is planned, then drained against the DUT.
module tb_seq_stage_ctrl;

    logic        clk, rst_n, start;
    logic [3:0]  icode, ifun;
    logic        instr_valid, imem_error, dmem_error;
    logic        alu_zf, alu_sf, alu_of, mem_ack;
    logic        f_en, d_en, e_en, m_en, w_en, pc_en, mem_req;
    logic [2:0]  cc;
    logic        cnd;
    logic [1:0]  stat;
    logic        busy;
    logic [31:0] retired, stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [6:0] exp;
        logic       ack;
        logic       derr;
    } step_t;
    step_t sb[$];

    logic [2:0] exp_cc;
    logic       exp_cnd;
    int         exp_retired, exp_stall;

    seq_stage_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .ifun(ifun),
        .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .mem_ack(mem_ack),
        .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc_en(pc_en),
        .mem_req(mem_req), .cc(cc), .cnd(cnd), .stat(stat), .busy(busy),
        .retired(retired), .stall_cycles(stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int perf(input int v);
`ifdef SEQ_CTRL_PERF_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic logic cond(input logic [2:0] c, input logic [3:0] f);
        logic z, s, o;
        z = c[2];
        s = c[1];
        o = c[0];
        case (f)
            4'h0: return 1'b1;
            4'h1: return (s ^ o) | z;
            4'h2: return s ^ o;
            4'h3: return z;
            4'h4: return ~z;
            4'h5: return ~(s ^ o);
            4'h6: return ~(s ^ o) & ~z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [6:0] e, input logic ack, input logic derr);
        step_t s;
        s.exp  = e;
        s.ack  = ack;
        s.derr = derr;
        sb.push_back(s);
    endtask

    task automatic drain();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            mem_ack    = s.ack;
            dmem_error = s.derr;
            #1;
            check("strobes{f,d,e,m,w,pc,req}",
                  32'({f_en, d_en, e_en, m_en, w_en, pc_en, mem_req}), 32'(s.exp));
            @(posedge clk);
            #1;
        end
        mem_ack    = 1'b0;
        dmem_error = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cc"}, 32'(cc), 32'(exp_cc));
        check({tag, "_cnd"}, 32'(cnd), 32'(exp_cnd));
        check({tag, "_retired"}, retired, 32'(perf(exp_retired)));
        check({tag, "_stall"}, stall_cycles, 32'(perf(exp_stall)));
    endtask

    task automatic model_reset();
        exp_cc      = 3'b100;
        exp_cnd     = 1'b0;
        exp_retired = 0;
        exp_stall   = 0;
    endtask

    // Called with the DUT in FETCH, #1 after the edge.
    task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn,
                             input logic [2:0] flags, input int ack_delay);
        logic is_mem;
        icode = ic;
        ifun  = fn;
        {alu_zf, alu_sf, alu_of} = flags;
        instr_valid = 1'b1;
        imem_error  = 1'b0;
        is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        push(7'b1000000, 1'b0, 1'b0);
        push(7'b0100000, 1'b0, 1'b0);
        push(7'b0010000, 1'b0, 1'b0);
        if (is_mem) begin
            for (int i = 0; i < ack_delay; i++) push(7'b0000001, 1'b0, 1'b0);
            push(7'b0001001, 1'b1, 1'b0);
        end else begin
            push(7'b0001000, 1'b1, 1'b0);
        end
        push(7'b0000100, 1'b0, 1'b0);
        push(7'b0000010, 1'b0, 1'b0);
        exp_cnd = ((ic == 4'h2) || (ic == 4'h7)) ? cond(exp_cc, fn) : 1'b0;
        if (ic == 4'h6) exp_cc = flags;
        exp_retired++;
        if (is_mem) exp_stall += ack_delay;
        drain();
        check("next_fetch", 32'(f_en), 32'd1);
        check_state($sformatf("instr_%0h_%0h", ic, fn));
    endtask

    task automatic reset_and_start();
        rst_n = 1'b0;
        start = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_halt(input logic [3:0] ic, input logic valid, input logic imerr,
                            input logic [1:0] exp_stat, input string tag);
        icode       = ic;
        ifun        = 4'h0;
        instr_valid = valid;
        imem_error  = imerr;
        push(7'b1000000, 1'b0, 1'b0);
        drain();
        check({tag, "_stat"}, 32'(stat), 32'(exp_stat));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_quiet"}, 32'({f_en, d_en, e_en, m_en, w_en, pc_en, mem_req}), 32'd0);
        instr_valid = 1'b1;
        imem_error  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; icode = 4'h1; ifun = 4'h0;
        instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
        alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0; mem_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", 32'({f_en, d_en, e_en, m_en, w_en, pc_en, mem_req}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stat", 32'(stat), 32'd0);
        check_state("rst");

        // start coincident with reset release is ignored for one edge
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_at_release_busy", 32'(busy), 32'd0);
        check("start_at_release_f", 32'(f_en), 32'd0);
        @(posedge clk);
        #1;
        check("start_clean_f", 32'(f_en), 32'd1);
        start = 1'b0;

        run_instr(4'h6, 4'h1, 3'b010, 0);
        run_instr(4'h7, 4'h2, 3'b100, 0);
        run_instr(4'h7, 4'h3, 3'b100, 0);
        run_instr(4'h2, 4'h4, 3'b111, 0);
        run_instr(4'h6, 4'h0, 3'b101, 0);
        run_instr(4'h7, 4'h1, 3'b000, 0);
        run_instr(4'h7, 4'h9, 3'b000, 0);
        run_instr(4'h5, 4'h0, 3'b000, 3);
        run_instr(4'h4, 4'h0, 3'b000, 0);

        // reset in the middle of a memory wait
        icode = 4'h8;
        push(7'b1000000, 1'b0, 1'b0);
        push(7'b0100000, 1'b0, 1'b0);
        push(7'b0010000, 1'b0, 1'b0);
        push(7'b0000001, 1'b0, 1'b0);
        push(7'b0000001, 1'b0, 1'b0);
        drain();
        check("wait_req_before_rst", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_strobes", 32'({f_en, d_en, e_en, m_en, w_en, pc_en, mem_req}), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check_state("async_rst");
        @(posedge clk);
        #1;
        check("rst_held_strobes", 32'({f_en, d_en, e_en, m_en, w_en, pc_en, mem_req}), 32'd0);

        reset_and_start();
        run_halt(4'h3, 1'b0, 1'b0, 2'd3, "ins");
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("halted_sticky_stat", 32'(stat), 32'd3);
        check("halted_sticky_busy", 32'(busy), 32'd0);

        reset_and_start();
        run_halt(4'h0, 1'b1, 1'b0, 2'd1, "hlt");

        reset_and_start();
        run_halt(4'h3, 1'b0, 1'b1, 2'd2, "imem_adr");

        // data-memory timeout after MEM_TIMEOUT wait cycles
        reset_and_start();
        icode = 4'h5;
        push(7'b1000000, 1'b0, 1'b0);
        push(7'b0100000, 1'b0, 1'b0);
        push(7'b0010000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(7'b0000001, 1'b0, 1'b0);
        drain();
        exp_stall = 4;
        check("timeout_stat", 32'(stat), 32'd2);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_quiet", 32'({f_en, d_en, e_en, m_en, w_en, pc_en, mem_req}), 32'd0);
        check_state("timeout");

        // data-memory error reported with the acknowledge
        reset_and_start();
        icode = 4'h9;
        push(7'b1000000, 1'b0, 1'b0);
        push(7'b0100000, 1'b0, 1'b0);
        push(7'b0010000, 1'b0, 1'b0);
        push(7'b0000001, 1'b0, 1'b0);
        push(7'b0000001, 1'b1, 1'b1);
        drain();
        exp_stall = 1;
        check("dmem_err_stat", 32'(stat), 32'd2);
        check("dmem_err_busy", 32'(busy), 32'd0);
        check_state("dmem_err");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Multi-cycle stage sequencer for the sequential Y86-64 core. Steps one instruction at a time through fetch, decode, execute, memory, write-back and PC-update, strobing each stage's enable. Owns the architectural condition-code register and the registered branch/move condition `cnd`. Handles the data-memory request/acknowledge handshake and the processor status code.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum cycles to wait for `mem_ack` before raising an address error. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  leaves IDLE; ignored in every other state.
- `icode`  in  4  instruction code from fetch; stable from the end of FETCH to the end of PCUPD.
- `ifun`  in  4  function code; same validity as `icode`.
- `instr_valid`  in  1  fetch reports a legal icode/ifun.
- `imem_error`  in  1  instruction-memory address error.
- `dmem_error`  in  1  data-memory error; sampled only together with `mem_ack`.
- `alu_zf`, `alu_sf`, `alu_of`  in  1 each  ALU flags for the current operands; valid in EXECUTE.
- `mem_ack`  in  1  data-memory access complete.
- `f_en`, `d_en`, `e_en`, `m_en`, `w_en`, `pc_en`  out  1 each  stage strobes.
- `mem_req`  out  1  data-memory request.
- `cc`  out  3  condition codes `{zf,sf,of}`.
- `cnd`  out  1  registered condition result.
- `stat`  out  2  status code: 0 = AOK, 1 = HLT, 2 = ADR, 3 = INS.
- `busy`  out  1  high in every state except IDLE and HALTED.
- `retired`  out  32  count of retired instructions.
- `stall_cycles`  out  32  count of memory wait cycles.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- Transitions:
  - IDLE→FETCH when `start`=1.
  - FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK→PCUPD→FETCH. Once started, the sequencer is free-running.
- Stage strobes are Moore outputs and one-hot:
  - `f_en`, `d_en`, `e_en`, `w_en` and `pc_en` are high for exactly the one cycle spent in their state.
  - `m_en` is high only in the MEMORY cycle that completes the stage.
- FETCH exit check, in priority order:
  - `imem_error` → `stat`=2 (ADR).
  - else `!instr_valid` → `stat`=3 (INS).
  - else `icode`=0 → `stat`=1 (HLT).
  - Any of these goes to HALTED; no further strobes are issued.
- Memory access is needed for icode 4, 5, 8, 9, A and B.
  - With access: `mem_req`=1 in every MEMORY cycle. The stage completes in the cycle `mem_ack`=1.
  - Without access: MEMORY lasts 1 cycle with `m_en`=1 and `mem_req`=0.
  - `mem_ack` is ignored whenever `mem_req`=0.
- Wait counter (8-bit):
  - Cleared on entry to MEMORY.
  - Increments each cycle with `mem_req`=1 and `mem_ack`=0.
  - When it reaches `MEM_TIMEOUT` → `stat`=2, HALTED, `mem_req` drops.
- `mem_ack`=1 with `dmem_error`=1 → `stat`=2, HALTED, and `m_en` is not asserted.
- Condition codes: at the EXECUTE clock edge, when `icode`=6, `cc` ← `{alu_zf,alu_sf,alu_of}`. `cc` is unchanged for all other icodes.
- `cnd` is registered at the EXECUTE edge from the pre-update `cc`, for icode 2 or 7. Conditions by ifun:
  - 0: always 1.
  - 1: (sf^of)|zf.
  - 2: sf^of.
  - 3: zf.
  - 4: ~zf.
  - 5: ~(sf^of).
  - 6: ~(sf^of)&~zf.
  - 7–F: 0.
- For other icodes, `cnd` ← 0. `cnd` is held until the next EXECUTE.
- HALTED is left only by reset.

## Timing
- Reset values:
  - State IDLE.
  - All strobes 0, `mem_req`=0, `busy`=0.
  - `cc`=3'b100, `cnd`=0, `stat`=0.
  - Counters 0, wait counter 0.
- Non-memory instruction: 6 cycles from FETCH to the next FETCH.
- Memory instruction: 6 + N cycles, where N = cycles with `mem_ack` low.
- `mem_ack` already high in the first MEMORY cycle gives zero wait cycles.
- `rst_n` asserted mid-instruction (including during a memory wait) clears all outputs immediately, asynchronously. No partial strobe may follow.
- `start` asserted in the same cycle reset is released is ignored; `start` is honoured on the first clean edge.

## Configuration
- Macro `SEQ_CTRL_PERF_EN`.
- Defined:
  - `retired` increments at every PCUPD cycle.
  - `stall_cycles` increments every MEMORY cycle with `mem_req`=1 and `mem_ack`=0.
  - Both wrap modulo 2^32 and both clear on reset.
- Undefined: the ports remain, driven constant 0, and no counter flops are built.

## Test plan
- Reset then `start`, with icode=6 ifun=1 and ALU flags 0/1/0 → strobes f,d,e,m,w,pc on cycles 1–6, `cc`=3'b010, `mem_req` never high.
- With `cc`=3'b010, icode=7 ifun=2 → `cnd`=1 after EXECUTE. Same with ifun=3 → `cnd`=0.
- icode=5 with `mem_ack` delayed 3 cycles → `mem_req` high for 4 cycles, `m_en` on the 4th, instruction takes 9 cycles, `stall_cycles`=3 (macro defined).
- `MEM_TIMEOUT`=4 and `mem_ack` held low → `stat`=2, HALTED after 4 wait cycles, `busy`=0, `mem_req`=0.
- FETCH with `instr_valid`=0 → `stat`=3. With icode=0 → `stat`=1. With `imem_error`=1 and `instr_valid`=0 → `stat`=2.
- `rst_n` pulsed low during a memory wait → all outputs reset within the same cycle, state IDLE, `cc`=3'b100.
